pcs_rx_link_ctrl: RTL and testbench

Link bring-up and supervision controller for the PCS receive path. It waits for SerDes lock, then all-lane block lock, then, in 40G mode, all-lane alignment marker lock, before declaring link up. While locked it runs a sync-header BER monitor. On any lock loss, high BER or AM lock timeout, it pulses a per-lane restart into the block sync stage and re-sequences. It sits beside the lane gearbox, block sync and AM lock instances and drives their restart and the MAC-facing link status.

---
 rtl/pcs_rx_link_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_pcs_rx_link_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcs_rx_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pcs_rx_link_ctrl
// Brief    : PCS receive link bring-up / supervision FSM with sync-header
//            BER monitor; pulses per-lane restart on any lock loss.
// Build    : define PCS_RX_LINK_CTRL_BER_EN to build the BER monitor and
//            err_cnt_o; otherwise hi_ber_o/err_cnt_o are tied low.
// Revision : 1.0 - initial release
// ============================================================================
module pcs_rx_link_ctrl #(
    parameter int IS_10G         = 0,
    parameter int LANE_N         = (IS_10G != 0) ? 1 : 4,
    parameter int HEAD_W         = 2,
    parameter int WINDOW_CYC     = 19531,
    parameter int BER_THRESH     = 16,
    parameter int HOLDOFF_CYC    = 1024,
    parameter int AM_TIMEOUT_CYC = 65536
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [LANE_N-1:0]        serdes_lock_v_i,
    input  logic [LANE_N-1:0]        hdr_v_i,
    input  logic [LANE_N*HEAD_W-1:0] head_i,
    input  logic [LANE_N-1:0]        bs_lock_v_i,
    input  logic [LANE_N-1:0]        am_lock_v_i,
    output logic [LANE_N-1:0]        restart_o,
    output logic                     link_up_o,
    output logic                     hi_ber_o,
    output logic [7:0]               err_cnt_o,
    output logic [2:0]               state_o
);

    localparam int c_tmr_max = (HOLDOFF_CYC > AM_TIMEOUT_CYC) ? HOLDOFF_CYC : AM_TIMEOUT_CYC;
    localparam int c_tmr_w   = $clog2(c_tmr_max + 1);

    localparam logic [c_tmr_w-1:0] c_holdoff_last = c_tmr_w'(HOLDOFF_CYC - 1);
    localparam logic [c_tmr_w-1:0] c_am_last      = c_tmr_w'(AM_TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_RESET       = 3'd0,
        ST_WAIT_SERDES = 3'd1,
        ST_WAIT_BLOCK  = 3'd2,
        ST_WAIT_AM     = 3'd3,
        ST_LINK_UP     = 3'd4,
        ST_RESTART     = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_tmr_w-1:0]  r_tmr;
    logic                r_link_up;
    logic [LANE_N-1:0]   r_restart;

    logic w_serdes_all;
    logic w_bs_all;
    logic w_am_all;
    logic w_am_fault;
    logic w_hi_ber;
    logic w_fault;

    assign w_serdes_all = &serdes_lock_v_i;
    assign w_bs_all     = &bs_lock_v_i;
    assign w_am_all     = &am_lock_v_i;
    // A 10G path has no alignment markers, so AM lock can never fault it.
    assign w_am_fault   = (IS_10G == 0) && !w_am_all;

    always_comb begin
        w_fault = 1'b0;
        case (r_state)
            ST_WAIT_BLOCK: w_fault = !w_serdes_all;
            ST_WAIT_AM:    w_fault = !w_serdes_all || !w_bs_all;
            ST_LINK_UP:    w_fault = !w_serdes_all || !w_bs_all || w_am_fault || w_hi_ber;
            default:       w_fault = 1'b0;
        endcase
    end

    // Fault is evaluated first so that it wins over forward progress.
    always_comb begin
        w_state_nxt = r_state;
        if (w_fault) begin
            w_state_nxt = ST_RESTART;
        end else begin
            case (r_state)
                ST_RESET: w_state_nxt = ST_WAIT_SERDES;
                ST_WAIT_SERDES: begin
                    if (w_serdes_all) w_state_nxt = ST_WAIT_BLOCK;
                end
                ST_WAIT_BLOCK: begin
                    if (w_bs_all) w_state_nxt = (IS_10G != 0) ? ST_LINK_UP : ST_WAIT_AM;
                end
                ST_WAIT_AM: begin
                    if (w_am_all)                w_state_nxt = ST_LINK_UP;
                    else if (r_tmr == c_am_last) w_state_nxt = ST_RESTART;
                end
                ST_LINK_UP: w_state_nxt = ST_LINK_UP;
                ST_RESTART: begin
                    if (r_tmr == c_holdoff_last) w_state_nxt = ST_WAIT_SERDES;
                end
                default: w_state_nxt = ST_RESET;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_RESET;
            r_link_up <= 1'b0;
            r_restart <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_link_up <= (w_state_nxt == ST_LINK_UP);
            r_restart <= {LANE_N{w_state_nxt == ST_RESTART}};
        end
    end

    // Shared timer: zeroed on every state change, only counts where it is read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmr <= '0;
        end else if (w_state_nxt != r_state) begin
            r_tmr <= '0;
        end else if (r_state == ST_RESTART || r_state == ST_WAIT_AM) begin
            r_tmr <= r_tmr + c_tmr_w'(1);
        end
    end

    assign state_o   = r_state;
    assign link_up_o = r_link_up;
    assign restart_o = r_restart;

`ifdef PCS_RX_LINK_CTRL_BER_EN
    localparam int c_inc_w = $clog2(LANE_N + 1);
    localparam int c_ber_w = $clog2(BER_THRESH + 1);
    localparam int c_sum_w = $clog2(BER_THRESH + LANE_N + 1);
    localparam int c_win_w = $clog2(WINDOW_CYC + 1);

    localparam logic [c_win_w-1:0] c_win_last = c_win_w'(WINDOW_CYC - 1);
    localparam logic [c_sum_w-1:0] c_thresh   = c_sum_w'(BER_THRESH);

    logic [LANE_N-1:0]   w_bad;
    logic [c_inc_w-1:0]  w_inc;
    logic [c_sum_w-1:0]  w_sum;
    logic                w_over;
    logic                w_ber_active;
    logic [8:0]          w_err_sum;
    logic [c_win_w-1:0]  r_win;
    logic [c_ber_w-1:0]  r_ber_cnt;
    logic                r_hi_ber;
    logic [7:0]          r_err_cnt;

    generate
        for (genvar l = 0; l < LANE_N; l++) begin : g_lane
            logic [HEAD_W-1:0] w_head;
            assign w_head   = head_i[l*HEAD_W +: HEAD_W];
            assign w_bad[l] = hdr_v_i[l] && ((w_head == '0) || (w_head == '1));
        end
    endgenerate

    always_comb begin
        w_inc = '0;
        for (int l = 0; l < LANE_N; l++) begin
            w_inc = w_inc + c_inc_w'(w_bad[l]);
        end
    end

    assign w_sum        = c_sum_w'(r_ber_cnt) + c_sum_w'(w_inc);
    assign w_over       = (w_sum >= c_thresh);
    assign w_ber_active = (r_state == ST_WAIT_AM) || (r_state == ST_LINK_UP);

    // Wrap-cycle errors belong to the closing window before the reload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win     <= '0;
            r_ber_cnt <= '0;
            r_hi_ber  <= 1'b0;
        end else if (!w_ber_active) begin
            r_win     <= '0;
            r_ber_cnt <= '0;
            r_hi_ber  <= 1'b0;
        end else if (r_win == c_win_last) begin
            r_win     <= '0;
            r_ber_cnt <= '0;
            r_hi_ber  <= w_over;
        end else begin
            r_win     <= r_win + c_win_w'(1);
            r_ber_cnt <= w_over ? c_ber_w'(BER_THRESH) : c_ber_w'(w_sum);
            if (w_over) r_hi_ber <= 1'b1;
        end
    end

    assign w_err_sum = {1'b0, r_err_cnt} + 9'(w_inc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_cnt <= '0;
        end else if (w_state_nxt == ST_WAIT_SERDES && r_state != ST_WAIT_SERDES) begin
            r_err_cnt <= '0;
        end else if (r_state == ST_LINK_UP) begin
            r_err_cnt <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
        end
    end

    assign w_hi_ber  = r_hi_ber;
    assign hi_ber_o  = r_hi_ber;
    assign err_cnt_o = r_err_cnt;
`else
    logic w_unused_ber;
    assign w_unused_ber = ^{hdr_v_i, head_i, WINDOW_CYC[0], BER_THRESH[0]};

    assign w_hi_ber  = 1'b0;
    assign hi_ber_o  = 1'b0;
    assign err_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pcs_rx_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcs_rx_link_ctrl
// Brief    : Directed self-checking bench for pcs_rx_link_ctrl (40G, small
//            window/threshold/hold-off/timeout values).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcs_rx_link_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] serdes_lock_v_i = '0;
    logic [3:0] hdr_v_i = '0;
    logic [7:0] head_i = 8'b0101_0101;
    logic [3:0] bs_lock_v_i = '0;
    logic [3:0] am_lock_v_i = '0;
    logic [3:0] restart_o;
    logic       link_up_o;
    logic       hi_ber_o;
    logic [7:0] err_cnt_o;
    logic [2:0] state_o;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [7:0] c_head_ok    = 8'b0101_0101;
    localparam logic [7:0] c_head_bad01 = 8'b0101_0000;
`ifdef PCS_RX_LINK_CTRL_BER_EN
    localparam bit c_ber_en = 1'b1;
`else
    localparam bit c_ber_en = 1'b0;
`endif

    pcs_rx_link_ctrl #(
        .IS_10G         (0),
        .HEAD_W         (2),
        .WINDOW_CYC     (100),
        .BER_THRESH     (4),
        .HOLDOFF_CYC    (8),
        .AM_TIMEOUT_CYC (50)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .serdes_lock_v_i (serdes_lock_v_i),
        .hdr_v_i         (hdr_v_i),
        .head_i          (head_i),
        .bs_lock_v_i     (bs_lock_v_i),
        .am_lock_v_i     (am_lock_v_i),
        .restart_o       (restart_o),
        .link_up_o       (link_up_o),
        .hi_ber_o        (hi_ber_o),
        .err_cnt_o       (err_cnt_o),
        .state_o         (state_o)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        step(3);
        n_vec++;
        if ({state_o, link_up_o, hi_ber_o, restart_o, err_cnt_o} !== 17'd0) begin
            n_err++;
            $display("FAIL reset_outputs: st=%0d lu=%0b hb=%0b rs=%0h ec=%0d, required all 0",
                     state_o, link_up_o, hi_ber_o, restart_o, err_cnt_o);
        end
        reset = 1'b0;
        n_vec++;
        if (state_o !== 3'd0) begin
            n_err++;
            $display("FAIL reset_release_state: got %0d, required 0", state_o);
        end
        step(1);
        n_vec++;
        if (state_o !== 3'd1) begin
            n_err++;
            $display("FAIL reset_to_wait_serdes: got %0d, required 1", state_o);
        end
    endtask

    task automatic test_bringup;
        for (int c = 0; c <= 21; c++) begin
            if (c == 1 || c == 10) begin
                n_vec++;
                if (state_o !== 3'd2) begin
                    n_err++;
                    $display("FAIL bringup_block c=%0d: state %0d, required 2", c, state_o);
                end
            end
            if (c == 11 || c == 20) begin
                n_vec++;
                if (state_o !== 3'd3 || link_up_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL bringup_am c=%0d: state %0d lu %0b, required 3/0", c, state_o, link_up_o);
                end
            end
            if (c == 21) begin
                n_vec++;
                if (state_o !== 3'd4 || link_up_o !== 1'b1 || restart_o !== 4'h0) begin
                    n_err++;
                    $display("FAIL bringup_up: state %0d lu %0b rs %0h, required 4/1/0", state_o, link_up_o, restart_o);
                end
            end
            if (c == 0)  serdes_lock_v_i = 4'hF;
            if (c == 10) bs_lock_v_i = 4'hF;
            if (c == 20) am_lock_v_i = 4'hF;
            if (c < 21) step(1);
        end
    endtask

    task automatic test_lock_loss;
        am_lock_v_i = 4'hD;
        step(1);
        n_vec++;
        if (state_o !== 3'd5 || link_up_o !== 1'b0 || restart_o !== 4'hF) begin
            n_err++;
            $display("FAIL lock_loss: state %0d lu %0b rs %0h, required 5/0/f", state_o, link_up_o, restart_o);
        end
        am_lock_v_i = 4'h7;
    endtask

    task automatic test_am_timeout;
        int n;
        n = 0;
        while (state_o !== 3'd3 && n < 40) begin step(1); n++; end
        n_vec++;
        if (state_o !== 3'd3) begin
            n_err++;
            $display("FAIL am_timeout_reach: state %0d, required 3", state_o);
        end
        n = 0;
        while (state_o === 3'd3 && n < 200) begin step(1); n++; end
        n_vec++;
        if (n !== 50) begin
            n_err++;
            $display("FAIL am_timeout_len: %0d cycles in WAIT_AM, required 50", n);
        end
        n_vec++;
        if (state_o !== 3'd5 || restart_o !== 4'hF) begin
            n_err++;
            $display("FAIL am_timeout_restart: state %0d rs %0h, required 5/f", state_o, restart_o);
        end
        n = 0;
        while (state_o === 3'd5 && restart_o === 4'hF && n < 100) begin step(1); n++; end
        n_vec++;
        if (n !== 8) begin
            n_err++;
            $display("FAIL holdoff_len: restart high %0d cycles, required 8", n);
        end
        n_vec++;
        if (state_o !== 3'd1 || restart_o !== 4'h0) begin
            n_err++;
            $display("FAIL holdoff_exit: state %0d rs %0h, required 1/0", state_o, restart_o);
        end
    endtask

    task automatic test_fault_vs_progress;
        int n;
        n = 0;
        while (state_o !== 3'd3 && n < 20) begin step(1); n++; end
        bs_lock_v_i = 4'hB;
        am_lock_v_i = 4'hF;
        step(1);
        n_vec++;
        if (state_o !== 3'd5 || link_up_o !== 1'b0) begin
            n_err++;
            $display("FAIL fault_priority: state %0d lu %0b, required 5/0", state_o, link_up_o);
        end
        bs_lock_v_i = 4'hF;
    endtask

    task automatic test_reset_mid_restart;
        step(3);
        n_vec++;
        if (restart_o !== 4'hF) begin
            n_err++;
            $display("FAIL holdoff_cycle3: rs %0h, required f", restart_o);
        end
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if (restart_o !== 4'h0 || state_o !== 3'd0 || link_up_o !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: rs %0h state %0d lu %0b, required 0/0/0", restart_o, state_o, link_up_o);
        end
        step(2);
        reset = 1'b0;
        n_vec++;
        if (state_o !== 3'd0) begin
            n_err++;
            $display("FAIL reset_rel_state: state %0d, required 0", state_o);
        end
        for (int c = 1; c <= 10; c++) begin
            step(1);
            n_vec++;
            if (restart_o !== 4'h0) begin
                n_err++;
                $display("FAIL no_restart_after_reset c=%0d: rs %0h, required 0", c, restart_o);
            end
            if (c == 1) begin
                n_vec++;
                if (state_o !== 3'd1) begin
                    n_err++;
                    $display("FAIL reset_resequence: state %0d, required 1", state_o);
                end
            end
        end
        n_vec++;
        if (state_o !== 3'd4 || link_up_o !== 1'b1) begin
            n_err++;
            $display("FAIL relink_after_reset: state %0d lu %0b, required 4/1", state_o, link_up_o);
        end
    endtask

    // Returns at the first cycle observed in LINK_UP with all locks held high.
    task automatic enter_link_up;
        int n;
        hdr_v_i = '0;
        head_i  = c_head_ok;
        serdes_lock_v_i = 4'h0;
        n = 0;
        while (state_o !== 3'd1 && n < 50) begin step(1); n++; end
        serdes_lock_v_i = 4'hF;
        bs_lock_v_i     = 4'hF;
        am_lock_v_i     = 4'hF;
        n = 0;
        while (state_o !== 3'd4 && n < 20) begin step(1); n++; end
        n_vec++;
        if (state_o !== 3'd4) begin
            n_err++;
            $display("FAIL enter_link_up: state %0d, required 4", state_o);
        end
    endtask

    task automatic test_hi_ber;
        enter_link_up();
        step(10);
        hdr_v_i = 4'b0011;
        head_i  = c_head_bad01;
        step(2);
        hdr_v_i = '0;
        head_i  = c_head_ok;
        n_vec++;
        if (hi_ber_o !== c_ber_en || link_up_o !== 1'b1) begin
            n_err++;
            $display("FAIL hi_ber_set: hb %0b lu %0b, required %0b/1", hi_ber_o, link_up_o, c_ber_en);
        end
        n_vec++;
        if (err_cnt_o !== (c_ber_en ? 8'd4 : 8'd0)) begin
            n_err++;
            $display("FAIL hi_ber_errcnt: %0d, required %0d", err_cnt_o, c_ber_en ? 4 : 0);
        end
        step(1);
        n_vec++;
        if (link_up_o !== !c_ber_en || state_o !== (c_ber_en ? 3'd5 : 3'd4)) begin
            n_err++;
            $display("FAIL hi_ber_link: lu %0b state %0d, required %0b/%0d",
                     link_up_o, state_o, !c_ber_en, c_ber_en ? 5 : 4);
        end
    endtask

    task automatic test_ber_below_thresh;
        enter_link_up();
        n_vec++;
        if (err_cnt_o !== 8'd0) begin
            n_err++;
            $display("FAIL errcnt_cleared: %0d, required 0", err_cnt_o);
        end
        for (int g = 0; g < 2; g++) begin
            step(g == 0 ? 10 : 97);
            hdr_v_i = 4'b0011;
            head_i  = c_head_bad01;
            step(1);
            hdr_v_i = 4'b0001;
            step(1);
            hdr_v_i = '0;
            head_i  = c_head_ok;
            step(1);
            n_vec++;
            if (hi_ber_o !== 1'b0 || link_up_o !== 1'b1 || state_o !== 3'd4) begin
                n_err++;
                $display("FAIL ber_below g=%0d: hb %0b lu %0b state %0d, required 0/1/4",
                         g, hi_ber_o, link_up_o, state_o);
            end
            n_vec++;
            if (err_cnt_o !== (c_ber_en ? 8'(3 * (g + 1)) : 8'd0)) begin
                n_err++;
                $display("FAIL ber_below_errcnt g=%0d: %0d, required %0d",
                         g, err_cnt_o, c_ber_en ? 3 * (g + 1) : 0);
            end
        end
        step(40);
        n_vec++;
        if (link_up_o !== 1'b1 || hi_ber_o !== 1'b0) begin
            n_err++;
            $display("FAIL ber_below_hold: lu %0b hb %0b, required 1/0", link_up_o, hi_ber_o);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        test_reset();
        test_bringup();
        test_lock_loss();
        test_am_timeout();
        test_fault_vs_progress();
        test_reset_mid_restart();
        test_hi_ber();
        test_ber_below_thresh();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
